deconv_frame_sched: RTL and testbench
=====================================

Name: deconv_frame_sched

Overview:
- Frame admission controller in front of the six-layer deconvolution decoder chain.
- Admits whole frames of the sop/eop/sof/eof pixel stream into the chain and drops frames that arrive while the chain is saturated or disabled.
- Tracks frames in flight using the chain's returned eof, checks frame geometry, and runs a watchdog on the chain output.

Parameters:
- DATA_WIDTH, 8, pixel width.
- STRING_LEN, 7, pixels per line (sop..eop).
- LINE_NUM, 1792, lines per frame (rows x channels).
- MAX_INFLIGHT, 2, maximum frames admitted but not yet returned (1..7).
- TIMEOUT_CYCLES, 1048576, watchdog limit in cycles.
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- enable_i  in  1  admission enable, sampled only at sof.
- clr_i  in  1  synchronous pulse; clears statistics counters and timeout_o.
- data_i  in  DATA_WIDTH  upstream pixel.
- data_valid_i  in  1  upstream beat valid. No backpressure: every valid beat is consumed.
- sop_i, eop_i, sof_i, eof_i  in  1 each  upstream line/frame markers, qualified by data_valid_i.
- data_o  out  DATA_WIDTH  pixel to decoder chain.
- data_valid_o  out  1  beat valid to chain.
- sop_o, eop_o, sof_o, eof_o  out  1 each  markers to chain.
- ret_valid_i, ret_eof_i  in  1 each  decoder chain output valid and eof.
- inflight_o  out  3  frames in flight.
- busy_o  out  1  high when FSM is not IDLE or inflight_o != 0.
- frames_in_o  out  STAT_W  admitted-frame count, saturating.
- frames_drop_o  out  STAT_W  dropped-frame count, saturating.
- frame_err_o  out  1  one-cycle error pulse.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset: all outputs 0, FSM IDLE, all counters 0.
- Forwarding: registered, latency exactly 1 cycle. data_o holds its last value when data_valid_o=0. Markers out are 0 unless data_valid_o=1.
- FSM IDLE: beats without sof are discarded, no error.
  - On a valid sof beat with enable_i=1 and inflight<MAX_INFLIGHT: forward the beat, inflight+1, frames_in+1, go PASS.
  - If that beat also has eof: stay IDLE.
  - Otherwise (disabled or saturated): go DROP, frames_drop+1, beat not forwarded.
- FSM PASS: forward every valid beat.
  - Pixel counter counts 0..STRING_LEN-1 per line; line counter counts 0..LINE_NUM-1 per frame.
  - A mid-frame sof: forwarded with sof_o forced to 0, frame_err pulse, counters not reset.
  - On valid eof: go IDLE. If eof does not coincide with eop, pixel=STRING_LEN-1 and line=LINE_NUM-1, frame_err pulses one cycle after that beat. The frame still counts as admitted.
  - An eop whose pixel count != STRING_LEN-1 pulses frame_err, and the pixel counter restarts.
  - enable_i falling mid-frame has no effect; the frame completes.
- FSM DROP: discard all beats; on valid eof go IDLE. A sof seen in DROP is ignored.
- Inflight accounting:
  - Decrement on ret_valid_i & ret_eof_i.
  - Simultaneous admit and return leaves the count unchanged.
  - A return with inflight=0 is ignored and pulses frame_err.
- Watchdog:
  - Counter clears when inflight=0 or on any ret_valid_i; otherwise increments.
  - At TIMEOUT_CYCLES-1: set timeout_o and force inflight to 0. The FSM state is unaffected.
  - timeout_o clears on clr_i or reset only.
- clr_i clears frames_in_o, frames_drop_o and timeout_o the next cycle. An increment in the same cycle as clr_i is lost (clear wins).
- Saturating counters hold at all-ones.
- Reset asserted mid-frame: the chain sees no eof. Recovering the chain is the system's responsibility.

Decomposition:
- Package deconv_ctrl_pkg holds:
  - enum state_t {IDLE, PASS, DROP};
  - localparam STAT_W_DEF = 16;
  - function sat_inc.
- One sub-module, deconv_frame_check: pixel and line counters plus the geometry/eop error logic. It is instantiated in PASS only, is reset by admission, and outputs a geometry error pulse.

Test Plan:
Bench config: STRING_LEN=4, LINE_NUM=2, MAX_INFLIGHT=2, TIMEOUT_CYCLES=64.
1. Two well-formed 8-beat frames, no returns → both forwarded with 1-cycle latency; inflight_o=2, frames_in_o=2, frame_err_o never high.
2. A third frame while inflight=2 → data_valid_o stays 0 for all 8 beats; frames_drop_o=1; issue one ret eof, then a fourth frame → admitted, inflight_o returns to 2.
3. Frame with eof on beat 6 (line 1, pixel 1) → forwarded, frame_err_o single pulse the cycle after eof_o, FSM IDLE.
4. sof asserted on beat 3 of an admitted frame → data_valid_o=1 with sof_o=0 on that beat, one frame_err pulse, frame completes normally.
5. inflight=1 with no ret_valid_i for 64 cycles → timeout_o=1, inflight_o=0; clr_i pulse → timeout_o=0, counters 0.
6. ret eof and admitting sof in the same cycle at inflight=1 → inflight_o stays 1; reset asserted mid-PASS → all outputs 0 asynchronously.

Source files
------------

// File: rtl/deconv_ctrl_pkg.sv
// Shared types and helpers for the deconvolution frame admission controller.
package deconv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int STAT_W_DEF = 16;

    // Increment that holds at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/deconv_frame_check.sv
// Pixel/line position tracking for an admitted frame; flags eop and eof beats
// that land at the wrong place in the frame geometry.
module deconv_frame_check #(
    parameter int STRING_LEN = 7,
    parameter int LINE_NUM   = 1792
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic beat,
    input  logic eop,
    input  logic eof,
    output logic geom_err
);

    localparam int PW = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
    localparam int LW = (LINE_NUM > 1) ? $clog2(LINE_NUM) : 1;
    localparam logic [PW-1:0] PIX_LAST  = PW'(STRING_LEN - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINE_NUM - 1);

    logic [PW-1:0] pix_q, cur_pix;
    logic [LW-1:0] line_q, cur_line;
    logic          err_d;

    // The admitting sof beat is pixel 0 of line 0 regardless of leftover counts.
    always_comb begin
        cur_pix  = start ? '0 : pix_q;
        cur_line = start ? '0 : line_q;
        err_d    = 1'b0;
        if (beat) begin
            if (eop && (cur_pix != PIX_LAST)) err_d = 1'b1;
            if (eof && !(eop && (cur_pix == PIX_LAST) && (cur_line == LINE_LAST))) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_q    <= '0;
            line_q   <= '0;
            geom_err <= 1'b0;
        end else begin
            geom_err <= err_d;
            if (beat) begin
                if (eop || (cur_pix == PIX_LAST)) begin
                    pix_q <= '0;
                    if (eop) line_q <= (cur_line == LINE_LAST) ? '0 : cur_line + 1'b1;
                end else begin
                    pix_q  <= cur_pix + 1'b1;
                    line_q <= cur_line;
                end
            end
        end
    end

endmodule

// File: rtl/deconv_frame_sched.sv
// Whole-frame admission controller in front of the deconvolution decoder chain,
// with in-flight accounting from returned eof, geometry checks and a watchdog.
module deconv_frame_sched
    import deconv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int STRING_LEN     = 7,
    parameter int LINE_NUM       = 1792,
    parameter int MAX_INFLIGHT   = 2,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int STAT_W         = STAT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    input  logic                  sop_i,
    input  logic                  eop_i,
    input  logic                  sof_i,
    input  logic                  eof_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic                  sof_o,
    output logic                  eof_o,
    input  logic                  ret_valid_i,
    input  logic                  ret_eof_i,
    output logic [2:0]            inflight_o,
    output logic                  busy_o,
    output logic [STAT_W-1:0]     frames_in_o,
    output logic [STAT_W-1:0]     frames_drop_o,
    output logic                  frame_err_o,
    output logic                  timeout_o
);

    // Streams are valid-only: a beat transfers on every cycle its valid is high,
    // upstream and toward the chain alike; there is no ready/backpressure path.

    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    MAX_IF  = 3'(MAX_INFLIGHT);

    state_t        state_q, state_d;
    logic          admit, drop, pass_beat, fwd, sof_err;
    logic          ret_ok, ret_err, wd_fire, pend_err, geom_err;
    logic [WW-1:0] wd_q;

    always_comb begin
        admit     = (state_q == IDLE) && data_valid_i && sof_i && enable_i && (inflight_o < MAX_IF);
        drop      = (state_q == IDLE) && data_valid_i && sof_i && !admit;
        pass_beat = (state_q == PASS) && data_valid_i;
        fwd       = admit || pass_beat;
        sof_err   = pass_beat && sof_i;
        ret_ok    = ret_valid_i && ret_eof_i && (inflight_o != 3'd0);
        ret_err   = ret_valid_i && ret_eof_i && (inflight_o == 3'd0);
        wd_fire   = (inflight_o != 3'd0) && !ret_valid_i && (wd_q == WD_LAST);
        state_d   = state_q;
        case (state_q)
            IDLE:       if (data_valid_i && sof_i && !eof_i) state_d = admit ? PASS : DROP;
            PASS, DROP: if (data_valid_i && eof_i) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE) || (inflight_o != 3'd0);

    deconv_frame_check #(
        .STRING_LEN (STRING_LEN),
        .LINE_NUM   (LINE_NUM)
    ) u_check (
        .clk      (clk),
        .reset    (reset),
        .start    (admit),
        .beat     (fwd),
        .eop      (eop_i),
        .eof      (eof_i),
        .geom_err (geom_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            data_o        <= '0;
            data_valid_o  <= 1'b0;
            sop_o         <= 1'b0;
            eop_o         <= 1'b0;
            sof_o         <= 1'b0;
            eof_o         <= 1'b0;
            inflight_o    <= 3'd0;
            wd_q          <= '0;
            timeout_o     <= 1'b0;
            frames_in_o   <= '0;
            frames_drop_o <= '0;
            pend_err      <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_valid_o <= fwd;
            sop_o        <= fwd && sop_i;
            eop_o        <= fwd && eop_i;
            sof_o        <= admit;
            eof_o        <= fwd && eof_i;
            if (fwd) data_o <= data_i;

            // A watchdog expiry abandons every outstanding frame at once.
            if (wd_fire)                inflight_o <= 3'd0;
            else if (admit && !ret_ok)  inflight_o <= inflight_o + 3'd1;
            else if (ret_ok && !admit)  inflight_o <= inflight_o - 3'd1;

            if ((inflight_o == 3'd0) || ret_valid_i || wd_fire) wd_q <= '0;
            else                                                wd_q <= wd_q + 1'b1;

            if (clr_i)        timeout_o <= 1'b0;
            else if (wd_fire) timeout_o <= 1'b1;

            if (clr_i)      frames_in_o <= '0;
            else if (admit) frames_in_o <= STAT_W'(sat_inc(32'(frames_in_o), STAT_W));

            if (clr_i)     frames_drop_o <= '0;
            else if (drop) frames_drop_o <= STAT_W'(sat_inc(32'(frames_drop_o), STAT_W));

            // All error sources surface on frame_err_o one cycle after the output beat.
            pend_err    <= sof_err || ret_err;
            frame_err_o <= pend_err || geom_err;
        end
    end

endmodule

// File: tb/tb_deconv_frame_sched.sv
// Directed scenario bench for deconv_frame_sched (4 px/line, 2 lines, 2 in flight, 64-cycle watchdog).
module tb_deconv_frame_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_i, clr_i;
    logic [7:0]  data_i;
    logic        data_valid_i, sop_i, eop_i, sof_i, eof_i;
    logic [7:0]  data_o;
    logic        data_valid_o, sop_o, eop_o, sof_o, eof_o;
    logic        ret_valid_i, ret_eof_i;
    logic [2:0]  inflight_o;
    logic        busy_o;
    logic [15:0] frames_in_o, frames_drop_o;
    logic        frame_err_o, timeout_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] obs_v, obs_sof, obs_eof;
    logic [7:0] obs_d [8];
    logic [9:0] err_vec;

    deconv_frame_sched #(
        .DATA_WIDTH     (8),
        .STRING_LEN     (4),
        .LINE_NUM       (2),
        .MAX_INFLIGHT   (2),
        .TIMEOUT_CYCLES (64),
        .STAT_W         (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (enable_i),
        .clr_i         (clr_i),
        .data_i        (data_i),
        .data_valid_i  (data_valid_i),
        .sop_i         (sop_i),
        .eop_i         (eop_i),
        .sof_i         (sof_i),
        .eof_i         (eof_i),
        .data_o        (data_o),
        .data_valid_o  (data_valid_o),
        .sop_o         (sop_o),
        .eop_o         (eop_o),
        .sof_o         (sof_o),
        .eof_o         (eof_o),
        .ret_valid_i   (ret_valid_i),
        .ret_eof_i     (ret_eof_i),
        .inflight_o    (inflight_o),
        .busy_o        (busy_o),
        .frames_in_o   (frames_in_o),
        .frames_drop_o (frames_drop_o),
        .frame_err_o   (frame_err_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        data_valid_i = 1'b0;
        sop_i = 1'b0; eop_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
    endtask

    // Drives beats 0..eof_at of a 4x2 frame, recording outputs after each edge,
    // then two idle cycles so late error pulses are captured in err_vec.
    task automatic send_frame(input logic [7:0] base, input int eof_at, input int sof_at);
        obs_v = '0; obs_sof = '0; obs_eof = '0; err_vec = '0;
        for (int i = 0; i <= eof_at; i++) begin
            data_i       = base + 8'(i);
            data_valid_i = 1'b1;
            sop_i        = (i % 4 == 0);
            eop_i        = (i % 4 == 3);
            sof_i        = (i == 0) || (i == sof_at);
            eof_i        = (i == eof_at);
            @(posedge clk); #1;
            obs_v[i]   = data_valid_o;
            obs_d[i]   = data_o;
            obs_sof[i] = sof_o;
            obs_eof[i] = eof_o;
            err_vec[i] = frame_err_o;
        end
        idle_inputs();
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            err_vec[eof_at + k] = frame_err_o;
        end
    endtask

    task automatic ret_eof();
        ret_valid_i = 1'b1; ret_eof_i = 1'b1;
        @(posedge clk); #1;
        ret_valid_i = 1'b0; ret_eof_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [51:0] got;
        reset = 1'b1; enable_i = 1'b0; clr_i = 1'b0; data_i = '0;
        ret_valid_i = 1'b0; ret_eof_i = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        got = {data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, inflight_o, busy_o,
               frames_in_o, frames_drop_o, frame_err_o, timeout_o};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", got); end
    endtask

    task automatic test_two_frames();
        logic [10:0] exp_b, got_b;
        enable_i = 1'b1;
        for (int f = 0; f < 2; f++) begin
            send_frame(8'h10 + 8'(f * 16), 7, -1);
            for (int i = 0; i < 8; i++) begin
                exp_b = {1'b1, (i == 0), (i == 7), 8'h10 + 8'(f * 16) + 8'(i)};
                got_b = {obs_v[i], obs_sof[i], obs_eof[i], obs_d[i]};
                checks++;
                if (got_b !== exp_b) begin
                    errors++; $display("FAIL fwd_f%0d_b%0d: got %h expected %h", f, i, got_b, exp_b);
                end
            end
            checks++;
            if (err_vec !== 10'd0) begin errors++; $display("FAIL good_frame_err: got %b expected 0", err_vec); end
        end
        checks++;
        if (inflight_o !== 3'd2) begin errors++; $display("FAIL two_inflight: got %0d expected 2", inflight_o); end
        checks++;
        if (frames_in_o !== 16'd2) begin errors++; $display("FAIL two_frames_in: got %0d expected 2", frames_in_o); end
    endtask

    task automatic test_saturated_drop();
        send_frame(8'h30, 7, -1);
        checks++;
        if (obs_v !== 8'h00) begin errors++; $display("FAIL drop_valid: got %b expected 0", obs_v); end
        checks++;
        if (frames_drop_o !== 16'd1) begin errors++; $display("FAIL drop_count: got %0d expected 1", frames_drop_o); end
        ret_eof();
        checks++;
        if (inflight_o !== 3'd1) begin errors++; $display("FAIL ret_dec: got %0d expected 1", inflight_o); end
        send_frame(8'h38, 7, -1);
        checks++;
        if (obs_v !== 8'hFF) begin errors++; $display("FAIL readmit_valid: got %b expected ff", obs_v); end
        checks++;
        if ({inflight_o, frames_in_o} !== {3'd2, 16'd3}) begin
            errors++; $display("FAIL readmit_counts: got %0d/%0d expected 2/3", inflight_o, frames_in_o);
        end
    endtask

    task automatic test_early_eof();
        ret_eof();
        send_frame(8'h40, 5, -1);
        checks++;
        if ({obs_v[5:0], obs_eof[5], obs_d[5]} !== {6'h3F, 1'b1, 8'h45}) begin
            errors++; $display("FAIL early_eof_fwd: got %b/%b/%h expected 111111/1/45", obs_v[5:0], obs_eof[5], obs_d[5]);
        end
        checks++;
        if (err_vec !== 10'b00_0100_0000) begin errors++; $display("FAIL early_eof_err: got %b expected 0001000000", err_vec); end
        checks++;
        if ({inflight_o, frames_in_o} !== {3'd2, 16'd4}) begin
            errors++; $display("FAIL early_eof_counts: got %0d/%0d expected 2/4", inflight_o, frames_in_o);
        end
    endtask

    task automatic test_mid_sof();
        ret_eof();
        send_frame(8'h50, 7, 2);
        checks++;
        if ({obs_v[2], obs_sof[2], obs_d[2]} !== {1'b1, 1'b0, 8'h52}) begin
            errors++; $display("FAIL mid_sof_fwd: got %b%b/%h expected 10/52", obs_v[2], obs_sof[2], obs_d[2]);
        end
        checks++;
        if (err_vec !== 10'b00_0000_1000) begin errors++; $display("FAIL mid_sof_err: got %b expected 0000001000", err_vec); end
        checks++;
        if ({obs_v, obs_eof[7], frames_in_o} !== {8'hFF, 1'b1, 16'd5}) begin
            errors++; $display("FAIL mid_sof_complete: got %b/%b/%0d expected ff/1/5", obs_v, obs_eof[7], frames_in_o);
        end
    endtask

    task automatic test_watchdog();
        int n;
        ret_eof();
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (timeout_o === 1'b1) begin n = k; break; end
        end
        checks++;
        if (n != 64) begin errors++; $display("FAIL wd_latency: got %0d expected 64", n); end
        checks++;
        if ({timeout_o, inflight_o, busy_o} !== {1'b1, 3'd0, 1'b0}) begin
            errors++; $display("FAIL wd_state: got %b/%0d/%b expected 1/0/0", timeout_o, inflight_o, busy_o);
        end
        ret_eof();
        checks++;
        if (frame_err_o !== 1'b0) begin errors++; $display("FAIL stray_ret_early: got %b expected 0", frame_err_o); end
        @(posedge clk); #1;
        checks++;
        if ({frame_err_o, inflight_o} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL stray_ret_err: got %b/%0d expected 1/0", frame_err_o, inflight_o);
        end
        @(posedge clk); #1;
        checks++;
        if ({frame_err_o, timeout_o, frames_in_o, frames_drop_o} !== {1'b0, 1'b1, 16'd5, 16'd1}) begin
            errors++; $display("FAIL pre_clr: got %b/%b/%0d/%0d expected 0/1/5/1", frame_err_o, timeout_o, frames_in_o, frames_drop_o);
        end
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        checks++;
        if ({timeout_o, frames_in_o, frames_drop_o} !== 33'd0) begin
            errors++; $display("FAIL clr: got %b/%0d/%0d expected 0/0/0", timeout_o, frames_in_o, frames_drop_o);
        end
    endtask

    task automatic test_back_to_back_and_reset();
        logic [51:0] got;
        send_frame(8'h60, 7, -1);
        checks++;
        if ({inflight_o, frames_in_o} !== {3'd1, 16'd1}) begin
            errors++; $display("FAIL b2b_pre: got %0d/%0d expected 1/1", inflight_o, frames_in_o);
        end
        data_i = 8'h70; data_valid_i = 1'b1; sop_i = 1'b1; sof_i = 1'b1;
        ret_valid_i = 1'b1; ret_eof_i = 1'b1;
        @(posedge clk); #1;
        ret_valid_i = 1'b0; ret_eof_i = 1'b0;
        checks++;
        if ({inflight_o, data_valid_o, sof_o, data_o, frames_in_o} !== {3'd1, 1'b1, 1'b1, 8'h70, 16'd2}) begin
            errors++; $display("FAIL simul_admit_ret: got %0d/%b/%b/%h/%0d expected 1/1/1/70/2",
                               inflight_o, data_valid_o, sof_o, data_o, frames_in_o);
        end
        sop_i = 1'b0; sof_i = 1'b0;
        for (int i = 1; i < 3; i++) begin
            data_i = 8'h70 + 8'(i);
            @(posedge clk); #1;
        end
        checks++;
        if ({busy_o, data_valid_o, data_o} !== {1'b1, 1'b1, 8'h72}) begin
            errors++; $display("FAIL mid_pass: got %b/%b/%h expected 1/1/72", busy_o, data_valid_o, data_o);
        end
        #2 reset = 1'b1;
        #1;
        got = {data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, inflight_o, busy_o,
               frames_in_o, frames_drop_o, frame_err_o, timeout_o};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL async_reset: got %h expected 0", got); end
        idle_inputs();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy_o, data_valid_o} !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle: got %b%b expected 00", busy_o, data_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_two_frames();
        test_saturated_drop();
        test_early_eof();
        test_mid_sof();
        test_watchdog();
        test_back_to_back_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1, "simulation time limit");
    end

endmodule
